// File: rtl/reg_fifo_stream_reader_if.sv
// reg_fifo_stream_reader_if: FIFO read port plus registered output stream of the reader
interface reg_fifo_stream_reader_if #(
    parameter int DATA_W = 60,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              fifoEmpty;
    logic [DATA_W-1:0] fifoDataOut;
    logic              fifoPop;
    logic              outValid;
    logic [DATA_W-1:0] outData;
    logic              outReady;
    logic [CNT_W-1:0]  popCount;
    logic              busy;
    modport master (
        output flush, fifoEmpty, fifoDataOut, outReady,
        input  fifoPop, outValid, outData, popCount, busy
    );
    modport slave (
        input  flush, fifoEmpty, fifoDataOut, outReady,
        output fifoPop, outValid, outData, popCount, busy
    );
endinterface

// File: rtl/reg_fifo_stream_reader.sv
// reg_fifo_stream_reader: drains a show-ahead register FIFO into a 2-entry registered valid/ready stream
module reg_fifo_stream_reader #(
    parameter int DATA_W = 60,
    parameter int CNT_W  = 16
) (
    input logic                      clockCore,
    input logic                      resetCore,
    reg_fifo_stream_reader_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;
    occ_e              occ_q, occ_d;
    logic [DATA_W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pop_in, beat_out;
    always_comb begin
        // pop depends only on registered occupancy, never on outReady
        pop_in   = ~resetCore & ~bus.fifoEmpty & (bus.flush | (occ_q != TWO));
        beat_out = (occ_q != EMPTY) & bus.outReady;
        occ_d    = occ_q;
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        cnt_d    = cnt_q + CNT_W'(beat_out);
        if (bus.flush) occ_d = EMPTY;
        else case (occ_q)
            EMPTY: if (pop_in) begin
                occ_d   = ONE;
                slot0_d = bus.fifoDataOut;
            end
            ONE: if (pop_in & beat_out) slot0_d = bus.fifoDataOut;
            else if (pop_in) begin
                occ_d   = TWO;
                slot1_d = bus.fifoDataOut;
            end
            else if (beat_out) occ_d = EMPTY;
            TWO: if (beat_out) begin
                occ_d   = ONE;
                slot0_d = slot1_q;
            end
            default: occ_d = EMPTY;
        endcase
    end
    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            occ_q   <= EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= '0;
        end else begin
            occ_q   <= occ_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.fifoPop  = pop_in;
    assign bus.outValid = occ_q != EMPTY;
    assign bus.outData  = slot0_q;
    assign bus.popCount = cnt_q;
    assign bus.busy     = (occ_q != EMPTY) | ~bus.fifoEmpty;
endmodule

// File: tb/tb_reg_fifo_stream_reader.sv
// tb_reg_fifo_stream_reader: directed vector table plus FIFO-model sequences for the stream reader
module tb_reg_fifo_stream_reader;
    localparam int DATA_W = 60;
    localparam int CNT_W  = 16;
    logic clockCore = 1'b0;
    logic resetCore = 1'b1;
    always #5 clockCore = ~clockCore;
    reg_fifo_stream_reader_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) b();
    reg_fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clockCore(clockCore),
        .resetCore(resetCore),
        .bus(b.slave)
    );
    typedef struct packed {
        logic              fl, em;
        logic [DATA_W-1:0] din;
        logic              rdy, e_pop, e_busy, e_val;
        logic [DATA_W-1:0] e_dat;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;
    int tests = 0;
    int fails = 0;
    int pops, bad_pop, c0, p0;
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] rx[$];
    vec_t v[12];

    function automatic vec_t mk(input int fl, em, din, rdy, e_pop, e_busy, e_val, e_dat, e_cnt);
        mk.fl = fl[0]; mk.em = em[0]; mk.din = DATA_W'(din); mk.rdy = rdy[0];
        mk.e_pop = e_pop[0]; mk.e_busy = e_busy[0]; mk.e_val = e_val[0];
        mk.e_dat = DATA_W'(e_dat); mk.e_cnt = CNT_W'(e_cnt);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // one cycle against the queue FIFO model; entered and left 1 time unit after a rising edge
    task automatic tick(input logic rdy, input logic fl);
        logic p;
        b.outReady    = rdy;
        b.flush       = fl;
        b.fifoEmpty   = q.size() == 0;
        b.fifoDataOut = q.size() != 0 ? q[0] : '0;
        #1;
        p = b.fifoPop;
        if (p & b.fifoEmpty) bad_pop++;
        if (b.outValid & rdy) rx.push_back(b.outData);
        @(posedge clockCore); #1;
        if (p && q.size() != 0) begin
            void'(q.pop_front());
            pops++;
        end
    endtask

    task automatic do_reset();
        resetCore     = 1'b1;
        b.fifoEmpty   = 1'b1;
        b.flush       = 1'b0;
        b.outReady    = 1'b0;
        @(posedge clockCore); #1;
        resetCore = 1'b0;
        q.delete(); rx.delete();
        pops = 0; bad_pop = 0;
    endtask

    initial begin
        b.flush = 1'b0; b.outReady = 1'b0;
        b.fifoEmpty = 1'b0; b.fifoDataOut = DATA_W'(1);
        // reset with a non-empty FIFO
        @(posedge clockCore); #1;
        @(posedge clockCore); #1;
        chk("rst_pop", 64'(b.fifoPop), 64'd0);
        chk("rst_valid", 64'(b.outValid), 64'd0);
        chk("rst_cnt", 64'(b.popCount), 64'd0);
        chk("rst_data", 64'(b.outData), 64'd0);
        resetCore = 1'b0;
        #1;
        chk("rst_first_pop", 64'(b.fifoPop), 64'd1);
        // reset mid-burst drops buffered beats
        q = '{DATA_W'(1), DATA_W'(2), DATA_W'(3), DATA_W'(4)};
        pops = 0;
        repeat (3) tick(1'b0, 1'b0);
        chk("mid_valid", 64'(b.outValid), 64'd1);
        chk("mid_pops", 64'(pops), 64'd2);
        resetCore = 1'b1;
        #1;
        chk("mid_rst_pop", 64'(b.fifoPop), 64'd0);
        @(posedge clockCore); #1;
        chk("mid_rst_valid", 64'(b.outValid), 64'd0);
        chk("mid_rst_cnt", 64'(b.popCount), 64'd0);

        // table: fl em din rdy | pop busy (pre-edge) | valid data cnt (post-edge)
        v[0]  = mk(0, 0, 1, 0, 1, 1, 1, 1, 0);
        v[1]  = mk(0, 0, 2, 0, 1, 1, 1, 1, 0);
        v[2]  = mk(0, 0, 3, 0, 0, 1, 1, 1, 0);
        v[3]  = mk(0, 0, 3, 1, 0, 1, 1, 2, 1);
        v[4]  = mk(0, 0, 3, 1, 1, 1, 1, 3, 2);
        v[5]  = mk(0, 1, 0, 1, 0, 1, 0, 0, 3);
        v[6]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 3);
        v[7]  = mk(0, 0, 4, 1, 1, 1, 1, 4, 3);
        v[8]  = mk(1, 0, 5, 1, 1, 1, 0, 0, 4);
        v[9]  = mk(1, 0, 6, 1, 1, 1, 0, 0, 4);
        v[10] = mk(0, 1, 0, 1, 0, 0, 0, 0, 4);
        v[11] = mk(1, 1, 0, 0, 0, 0, 0, 0, 4);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            b.flush = v[i].fl; b.fifoEmpty = v[i].em;
            b.fifoDataOut = v[i].din; b.outReady = v[i].rdy;
            #1;
            chk($sformatf("vec%0d_pop", i), 64'(b.fifoPop), 64'(v[i].e_pop));
            chk($sformatf("vec%0d_busy", i), 64'(b.busy), 64'(v[i].e_busy));
            @(posedge clockCore); #1;
            chk($sformatf("vec%0d_valid", i), 64'(b.outValid), 64'(v[i].e_val));
            if (v[i].e_val) chk($sformatf("vec%0d_data", i), 64'(b.outData), 64'(v[i].e_dat));
            chk($sformatf("vec%0d_cnt", i), 64'(b.popCount), 64'(v[i].e_cnt));
        end

        // full throughput: 8 beats on 8 consecutive cycles after one fill cycle
        do_reset();
        for (int i = 1; i <= 8; i++) q.push_back(DATA_W'(i));
        repeat (9) tick(1'b1, 1'b0);
        chk("thru_n", 64'(rx.size()), 64'd8);
        for (int i = 0; i < 8 && i < rx.size(); i++)
            chk($sformatf("thru_beat%0d", i), 64'(rx[i]), 64'(i + 1));
        chk("thru_cnt", 64'(b.popCount), 64'd8);

        // backpressure: only two pops, head held, then release with no gap
        do_reset();
        for (int i = 1; i <= 8; i++) q.push_back(DATA_W'(i));
        repeat (4) tick(1'b0, 1'b0);
        chk("bp_pops", 64'(pops), 64'd2);
        chk("bp_pop_now", 64'(b.fifoPop), 64'd0);
        chk("bp_valid", 64'(b.outValid), 64'd1);
        chk("bp_hold", 64'(b.outData), 64'd1);
        repeat (3) tick(1'b1, 1'b0);
        chk("bp_n", 64'(rx.size()), 64'd3);
        for (int i = 0; i < 3 && i < rx.size(); i++)
            chk($sformatf("bp_beat%0d", i), 64'(rx[i]), 64'(i + 1));

        // toggling ready: order preserved, no underrun
        do_reset();
        for (int i = 1; i <= 6; i++) q.push_back(DATA_W'(i));
        for (int i = 0; i < 20; i++) tick(i % 2 == 0, 1'b0);
        chk("tog_n", 64'(rx.size()), 64'd6);
        for (int i = 0; i < 6 && i < rx.size(); i++)
            chk($sformatf("tog_beat%0d", i), 64'(rx[i]), 64'(i + 1));
        chk("tog_underrun", 64'(bad_pop), 64'd0);

        // flush with two buffered beats and three queued entries
        do_reset();
        for (int i = 1; i <= 5; i++) q.push_back(DATA_W'(i));
        repeat (3) tick(1'b0, 1'b0);
        chk("fl_pre_fifo", 64'(q.size()), 64'd3);
        c0 = int'(b.popCount); p0 = pops;
        tick(1'b0, 1'b1);
        chk("fl_valid", 64'(b.outValid), 64'd0);
        repeat (2) tick(1'b0, 1'b1);
        chk("fl_fifo_empty", 64'(q.size()), 64'd0);
        chk("fl_pops", 64'(pops - p0), 64'd3);
        chk("fl_cnt", 64'(b.popCount), 64'(c0));
        tick(1'b1, 1'b0);
        chk("fl_after_valid", 64'(b.outValid), 64'd0);
        chk("fl_after_busy", 64'(b.busy), 64'd0);
        chk("fl_underrun", 64'(bad_pop), 64'd0);

        // popCount wraparound after 65535 deliveries
        do_reset();
        for (int i = 1; i <= 65535; i++) q.push_back(DATA_W'(i));
        for (int i = 0; i < 70000 && b.popCount != '1; i++) begin
            tick(1'b1, 1'b0);
            rx.delete();
        end
        chk("wrap_pre", 64'(b.popCount), 64'hFFFF);
        q.push_back(DATA_W'(60'hABC));
        repeat (3) tick(1'b1, 1'b0);
        chk("wrap_cnt", 64'(b.popCount), 64'd0);
        chk("wrap_beat", 64'(rx.size() != 0 ? rx[rx.size() - 1] : '0), 64'hABC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
